// File: rtl/byte_serial_adder_if.sv
// Operand request and result/flags handshake bundle for byte_serial_adder.
// master drives operands and takes results; slave is the adder side.
interface byte_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero, negative
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero, negative
    );
endinterface

// File: rtl/byte_serial_adder.sv
// Purpose: WIDTH-bit add/subtract, one byte per cycle through a shared 8-bit lookahead slice.
// Latency: NSLICE cycles from operand accept to out_valid; one operation in flight at a time.
// Backpressure: holds result and flags in DONE until out_ready; in_ready only while idle.
module byte_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    byte_serial_adder_if.slave  bus
);
    localparam int NSLICE = WIDTH / 8;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              c_q, c_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;

    logic [7:0] a_byte, b_byte, p, g, cc, byte_sum;
    logic       term, pp;

    // Lookahead slice: every carry is a flat sum of products over the byte and c_q.
    always_comb begin
        a_byte   = a_q[8*idx_q +: 8];
        b_byte   = b_q[8*idx_q +: 8];
        p        = a_byte ^ b_byte;
        g        = a_byte & b_byte;
        cc       = '0;
        term     = 1'b0;
        pp       = 1'b0;
        for (int k = 0; k < 8; k++) begin
            term = g[k];
            pp   = p[k];
            for (int j = k - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            cc[k] = term | (pp & c_q);
        end
        byte_sum[0]   = p[0] ^ c_q;
        byte_sum[7:1] = p[7:1] ^ cc[6:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b ^ {WIDTH{bus.sub}};
                    c_d     = bus.sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[8*idx_q +: 8] = byte_sum;
                c_d   = cc[7];
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Flags see the full result including the byte written this cycle.
                    carry_d = cc[7];
                    ovf_d   = cc[6] ^ cc[7];
                    neg_d   = sum_d[WIDTH-1];
                    zero_d  = (sum_d == '0);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
endmodule
